// File: rtl/trireg_pkg.sv
// Shared encodings for the trireg sampler: FSM state codes and storage-strength codes.
package trireg_pkg;

  localparam logic [1:0] ST_EMPTY  = 2'b00;
  localparam logic [1:0] ST_DRIVEN = 2'b01;
  localparam logic [1:0] ST_HELD   = 2'b10;

  localparam logic [1:0] STR_NONE   = 2'b00;
  localparam logic [1:0] STR_SMALL  = 2'b01;
  localparam logic [1:0] STR_MEDIUM = 2'b10;
  localparam logic [1:0] STR_LARGE  = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/charge_decay_timer.sv
// Down-counter modelling how long a tri-stated net keeps its charge.
// load starts a hold of the strength-selected length; expire fires on the last held cycle.
module charge_decay_timer
  import trireg_pkg::*;
#(
  parameter int DECAY_SMALL  = 4,
  parameter int DECAY_MEDIUM = 16,
  parameter int DECAY_LARGE  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [1:0] i_strength,
  input  logic       i_abort,
  input  logic       i_tick,
  output logic       o_expire
);

  localparam int MAX_DECAY = max3(DECAY_SMALL, DECAY_MEDIUM, DECAY_LARGE);
  localparam int CW        = $clog2(MAX_DECAY + 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_load_val;

  always_comb begin
    w_load_val = '0;
    case (i_strength)
      STR_SMALL:  w_load_val = CW'(DECAY_SMALL);
      STR_MEDIUM: w_load_val = CW'(DECAY_MEDIUM);
      STR_LARGE:  w_load_val = CW'(DECAY_LARGE);
      default:    w_load_val = '0;
    endcase
  end

  assign o_expire = i_tick && (r_count == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_load_val;
    end else if (i_abort) begin
      r_count <= '0;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/trireg_sampler.sv
// Samples a tri-state bus, holds the last driven value for a strength-dependent time
// after the driver releases, and publishes value changes on a one-deep sample port.
module trireg_sampler
  import trireg_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DECAY_SMALL  = 4,
  parameter int DECAY_MEDIUM = 16,
  parameter int DECAY_LARGE  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             drv_en,
  input  logic [1:0]       strength,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [1:0]       state,
  output logic             decay_pulse,
  output logic [WIDTH-1:0] smp_data,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             smp_ovf
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_decay_pulse;
  logic [WIDTH-1:0] r_smp_data;
  logic             r_smp_valid;
  logic             r_smp_ovf;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_publish;
  logic             w_load;
  logic             w_abort;
  logic             w_tick;
  logic             w_expire;
  logic             w_pulse;

  charge_decay_timer #(
    .DECAY_SMALL (DECAY_SMALL),
    .DECAY_MEDIUM(DECAY_MEDIUM),
    .DECAY_LARGE (DECAY_LARGE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_strength(strength),
    .i_abort   (w_abort),
    .i_tick    (w_tick),
    .o_expire  (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_publish   = 1'b0;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    w_tick      = 1'b0;
    w_pulse     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (drv_en) begin
          w_state_nxt = ST_DRIVEN;
          w_data_nxt  = bus_in;
          w_publish   = 1'b1;
        end
      end
      ST_DRIVEN: begin
        if (drv_en) begin
          w_data_nxt = bus_in;
          w_publish  = (bus_in != r_data);
        end else if (strength == STR_NONE) begin
          // No storage: the net collapses immediately, which is not a timeout.
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_HELD;
          w_load      = 1'b1;
        end
      end
      ST_HELD: begin
        if (drv_en) begin
          w_state_nxt = ST_DRIVEN;
          w_data_nxt  = bus_in;
          w_publish   = 1'b1;
          w_abort     = 1'b1;
        end else begin
          w_tick = 1'b1;
          if (w_expire) begin
            w_state_nxt = ST_EMPTY;
            w_pulse     = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_decay_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_data        <= w_data_nxt;
      r_data_valid  <= (w_state_nxt == ST_DRIVEN) || (w_state_nxt == ST_HELD);
      r_decay_pulse <= w_pulse;
    end
  end

  // Sample port: a transfer happens on any edge where smp_valid && smp_ready.
  // A publish on that same edge refills the slot; a publish while the slot is
  // full and not being accepted overwrites it and sets the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp_valid <= 1'b0;
      r_smp_data  <= '0;
      r_smp_ovf   <= 1'b0;
    end else begin
      if (w_publish) begin
        r_smp_valid <= 1'b1;
        r_smp_data  <= w_data_nxt;
        if (r_smp_valid && !smp_ready) r_smp_ovf <= 1'b1;
      end else if (r_smp_valid && smp_ready) begin
        r_smp_valid <= 1'b0;
      end
    end
  end

  assign state       = r_state;
  assign data_out    = r_data;
  assign data_valid  = r_data_valid;
  assign decay_pulse = r_decay_pulse;
  assign smp_data    = r_smp_data;
  assign smp_valid   = r_smp_valid;
  assign smp_ovf     = r_smp_ovf;

endmodule
